// File: rtl/uart_program_loader.sv
// Boot loader between the UART cores and the CPU: handshakes with the host, loads a sized
// program as instruction words, then streams every later byte to data memory as words.
module uart_program_loader #(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned BYTE_ORDER = 0,
    parameter logic [7:0]  SYNC_BYTE  = 8'h99,
    parameter logic [7:0]  DONE_BYTE  = 8'hAA,
    parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx_ready,
    input  logic [7:0]              rdata,
    input  logic                    tx_busy,
    output logic                    tx_start,
    output logic [7:0]              sdata,
    output logic                    instr_ready,
    output logic [ADDR_W-1:0]       instr_addr,
    output logic                    mem_ready,
    output logic [8*WORD_BYTES-1:0] data,
    output logic                    program_loaded,
    output logic                    error
);

    localparam int unsigned    W         = 8 * WORD_BYTES;
    localparam int unsigned    BC_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(WORD_BYTES - 1);
    localparam logic [63:0]    MAX_BYTES = 64'(WORD_BYTES) << ADDR_W;

    typedef enum logic [2:0] {S_SYNC, S_SIZE, S_PROG, S_ACK, S_DATA, S_ERROR} state_t;

    state_t            r_state;
    logic [BC_W-1:0]   r_bcnt;
    logic [1:0]        r_scnt;
    logic [31:0]       r_size;
    logic [31:0]       r_remain;
    logic              r_tx_pend;
    logic [7:0]        r_pend_byte;
    logic              r_tx_start;
    logic [7:0]        r_sdata;
    logic              r_instr_ready;
    logic [ADDR_W-1:0] r_instr_addr;
    logic              r_mem_ready;
    logic [W-1:0]      r_data;
    logic              r_program_loaded;
    logic              r_error;

    logic [W-1:0]      w_data_next;
    logic [31:0]       w_size_full;
    logic              w_word_done;
    logic              w_size_bad;

    always_comb begin
        if (BYTE_ORDER == 0) begin
            w_data_next        = r_data << 8;
            w_data_next[7:0]   = rdata;
        end else begin
            w_data_next        = r_data >> 8;
            w_data_next[W-1 -: 8] = rdata;
        end
    end

    // Size field is always LSB first, independent of the word byte order.
    always_comb begin
        w_size_full = r_size;
        w_size_full[8*r_scnt +: 8] = rdata;
    end

    assign w_word_done = (r_bcnt == BC_LAST);
    assign w_size_bad  = ((w_size_full % WORD_BYTES) != 32'd0) ||
                         ({32'b0, w_size_full} > MAX_BYTES);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state          <= S_SYNC;
            r_bcnt           <= '0;
            r_scnt           <= '0;
            r_size           <= '0;
            r_remain         <= '0;
            r_tx_pend        <= 1'b0;
            r_pend_byte      <= '0;
            r_tx_start       <= 1'b0;
            r_sdata          <= '0;
            r_instr_ready    <= 1'b0;
            r_instr_addr     <= '0;
            r_mem_ready      <= 1'b0;
            r_data           <= '0;
            r_program_loaded <= 1'b0;
            r_error          <= 1'b0;
        end else begin
            r_tx_start    <= 1'b0;
            r_instr_ready <= 1'b0;
            r_mem_ready   <= 1'b0;

            if (r_instr_ready)
                r_instr_addr <= r_instr_addr + ADDR_W'(1);

            if (r_tx_pend && !tx_busy) begin
                r_tx_start <= 1'b1;
                r_sdata    <= r_pend_byte;
                r_tx_pend  <= 1'b0;
            end

            case (r_state)
                S_SYNC: begin
                    r_tx_pend   <= 1'b1;
                    r_pend_byte <= SYNC_BYTE;
                    r_state     <= S_SIZE;
                end
                S_SIZE: begin
                    if (rx_ready) begin
                        r_size <= w_size_full;
                        r_scnt <= r_scnt + 2'd1;
                        if (r_scnt == 2'd3) begin
                            if (w_size_bad) begin
                                r_state     <= S_ERROR;
                                r_tx_pend   <= 1'b1;
                                r_pend_byte <= ERR_BYTE;
                                r_error     <= 1'b1;
                            end else if (w_size_full == 32'd0) begin
                                r_state <= S_ACK;
                            end else begin
                                r_state      <= S_PROG;
                                r_remain     <= w_size_full;
                                r_instr_addr <= '0;
                            end
                        end
                    end
                end
                S_PROG: begin
                    if (rx_ready) begin
                        r_data   <= w_data_next;
                        r_bcnt   <= w_word_done ? '0 : r_bcnt + BC_W'(1);
                        r_remain <= r_remain - 32'd1;
                        if (w_word_done)
                            r_instr_ready <= 1'b1;
                        if (r_remain == 32'd1) begin
                            r_state <= S_ACK;
                            r_bcnt  <= '0;
                        end
                    end
                end
                // ACK lasts one cycle but already assembles data bytes so rx never stalls.
                S_ACK, S_DATA: begin
                    if (r_state == S_ACK) begin
                        r_tx_pend        <= 1'b1;
                        r_pend_byte      <= DONE_BYTE;
                        r_program_loaded <= 1'b1;
                        r_state          <= S_DATA;
                    end
                    if (rx_ready) begin
                        r_data <= w_data_next;
                        r_bcnt <= w_word_done ? '0 : r_bcnt + BC_W'(1);
                        if (w_word_done)
                            r_mem_ready <= 1'b1;
                    end
                end
                S_ERROR: begin
                end
                default: r_state <= S_SYNC;
            endcase
        end
    end

    assign tx_start       = r_tx_start;
    assign sdata          = r_sdata;
    assign instr_ready    = r_instr_ready;
    assign instr_addr     = r_instr_addr;
    assign mem_ready      = r_mem_ready;
    assign data           = r_data;
    assign program_loaded = r_program_loaded;
    assign error          = r_error;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: two instances (MSB-first and LSB-first) share one byte stream;
// expected events are derived per scenario from size/byte lists and compared with monitored pulses.
module tb_uart_program_loader;

    localparam int unsigned AW   = 4;
    localparam int unsigned MAXB = 4 << AW;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rdata = 8'h00;
    logic       tx_busy = 1'b0;

    logic          d0_tx_start, d0_instr_ready, d0_mem_ready, d0_program_loaded, d0_error;
    logic [7:0]    d0_sdata;
    logic [AW-1:0] d0_instr_addr;
    logic [31:0]   d0_data;
    logic          d1_tx_start, d1_instr_ready, d1_mem_ready, d1_program_loaded, d1_error;
    logic [7:0]    d1_sdata;
    logic [AW-1:0] d1_instr_addr;
    logic [31:0]   d1_data;

    always #5 clock = ~clock;

    uart_program_loader #(.WORD_BYTES(4), .ADDR_W(AW), .BYTE_ORDER(0)) u_dut0 (
        .clock(clock), .reset(reset), .rx_ready(rx_ready), .rdata(rdata), .tx_busy(tx_busy),
        .tx_start(d0_tx_start), .sdata(d0_sdata), .instr_ready(d0_instr_ready),
        .instr_addr(d0_instr_addr), .mem_ready(d0_mem_ready), .data(d0_data),
        .program_loaded(d0_program_loaded), .error(d0_error)
    );

    uart_program_loader #(.WORD_BYTES(4), .ADDR_W(AW), .BYTE_ORDER(1)) u_dut1 (
        .clock(clock), .reset(reset), .rx_ready(rx_ready), .rdata(rdata), .tx_busy(tx_busy),
        .tx_start(d1_tx_start), .sdata(d1_sdata), .instr_ready(d1_instr_ready),
        .instr_addr(d1_instr_addr), .mem_ready(d1_mem_ready), .data(d1_data),
        .program_loaded(d1_program_loaded), .error(d1_error)
    );

    typedef struct {
        logic [31:0] data;
        int          addr;
        int          cyc;
    } ev_t;

    typedef struct {
        logic [31:0] size;
        int          ndata;
        logic        exp_err;
        logic [7:0]  exp_tx;
    } vec_t;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  rel_cyc = 0;
    bit  busy_rand = 1'b0;

    ev_t t0[$], t1[$], i0[$], i1[$], m0[$], m1[$];
    logic [7:0] prog_q[$], data_q[$];
    int  prog_c[$], data_c[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (busy_rand) begin
            #1;
            tx_busy = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clock) begin
        if (d0_tx_start)    t0.push_back('{data: 32'(d0_sdata), addr: 0, cyc: cyc});
        if (d1_tx_start)    t1.push_back('{data: 32'(d1_sdata), addr: 0, cyc: cyc});
        if (d0_instr_ready) i0.push_back('{data: d0_data, addr: int'(d0_instr_addr), cyc: cyc});
        if (d1_instr_ready) i1.push_back('{data: d1_data, addr: int'(d1_instr_addr), cyc: cyc});
        if (d0_mem_ready)   m0.push_back('{data: d0_data, addr: 0, cyc: cyc});
        if (d1_mem_ready)   m1.push_back('{data: d1_data, addr: 0, cyc: cyc});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output int c);
        rx_ready = 1'b1;
        rdata    = b;
        @(posedge clock);
        #1;
        rx_ready = 1'b0;
        c = cyc;
        step(gap);
    endtask

    task automatic reset_and_sync(input bit junk);
        int n;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_zero_d0", {d0_tx_start, d0_sdata, d0_instr_ready, d0_instr_addr, d0_mem_ready,
                            d0_data, d0_program_loaded, d0_error}, 64'd0);
        chk("rst_zero_d1", {d1_tx_start, d1_sdata, d1_instr_ready, d1_instr_addr, d1_mem_ready,
                            d1_data, d1_program_loaded, d1_error}, 64'd0);
        t0.delete(); t1.delete(); i0.delete(); i1.delete(); m0.delete(); m1.delete();
        prog_c.delete(); data_c.delete();
        rx_ready = 1'b0;
        tx_busy  = 1'b0;
        step(1);
        if (junk) begin
            rx_ready = 1'b1;
            rdata    = 8'($urandom);
        end
        reset   = 1'b1;
        rel_cyc = cyc;
        step(1);
        rx_ready = 1'b0;
        n = 0;
        while (t0.size() == 0 && n < 20) begin
            step(1);
            n++;
        end
        chk("sync_byte", (t0.size() > 0) ? 64'(t0[0].data) : 64'hx, 64'h99);
        chk("sync_latency_le2", (t0.size() > 0) ? 64'((t0[0].cyc - rel_cyc) <= 2) : 64'hx, 64'd1);
    endtask

    task automatic cmp_q(input string name, input ev_t act[$], input ev_t exp[$]);
        chk({name, "_count"}, 64'(act.size()), 64'(exp.size()));
        for (int k = 0; k < exp.size() && k < act.size(); k++) begin
            chk({name, "_word"}, {16'(act[k].addr), act[k].data}, {16'(exp[k].addr), exp[k].data});
            chk({name, "_cycle"}, 64'(act[k].cyc), 64'(exp[k].cyc));
        end
    endtask

    // Reference: expected events derived from the size field and the byte lists alone.
    task automatic check_model(input logic [31:0] size);
        bit  bad;
        ev_t e0[$], e1[$], f0[$], f1[$];
        int  nw;
        bad = ((size % 4) != 0) || (longint'(size) > longint'(MAXB));
        if (!bad) begin
            nw = int'(size) / 4;
            for (int w = 0; w < nw; w++) begin
                e0.push_back('{data: {prog_q[4*w], prog_q[4*w+1], prog_q[4*w+2], prog_q[4*w+3]},
                               addr: w, cyc: prog_c[4*w+3]});
                e1.push_back('{data: {prog_q[4*w+3], prog_q[4*w+2], prog_q[4*w+1], prog_q[4*w]},
                               addr: w, cyc: prog_c[4*w+3]});
            end
            nw = data_q.size() / 4;
            for (int w = 0; w < nw; w++) begin
                f0.push_back('{data: {data_q[4*w], data_q[4*w+1], data_q[4*w+2], data_q[4*w+3]},
                               addr: 0, cyc: data_c[4*w+3]});
                f1.push_back('{data: {data_q[4*w+3], data_q[4*w+2], data_q[4*w+1], data_q[4*w]},
                               addr: 0, cyc: data_c[4*w+3]});
            end
        end
        chk("tx_count_d0", 64'(t0.size()), 64'd2);
        chk("tx_count_d1", 64'(t1.size()), 64'd2);
        chk("tx_second_d0", (t0.size() > 1) ? 64'(t0[1].data) : 64'hx, bad ? 64'hEE : 64'hAA);
        chk("tx_second_d1", (t1.size() > 1) ? 64'(t1[1].data) : 64'hx, bad ? 64'hEE : 64'hAA);
        cmp_q("instr_d0", i0, e0);
        cmp_q("instr_d1", i1, e1);
        cmp_q("mem_d0", m0, f0);
        cmp_q("mem_d1", m1, f1);
        chk("flags_d0", {d0_error, d0_program_loaded}, {bad, !bad});
        chk("flags_d1", {d1_error, d1_program_loaded}, {bad, !bad});
    endtask

    task automatic run_scenario(input logic [31:0] size, input int busy_mode, input int gap_max,
                                input bit junk);
        int c;
        reset_and_sync(junk);
        if (busy_mode == 2) tx_busy = 1'b1;
        for (int k = 0; k < 4; k++)
            send_byte(size[8*k +: 8], $urandom_range(0, gap_max), c);
        if (busy_mode == 1) busy_rand = 1'b1;
        foreach (prog_q[k]) begin
            send_byte(prog_q[k], $urandom_range(0, gap_max), c);
            prog_c.push_back(c);
        end
        if (busy_mode == 2) begin
            step(20);
            chk("busy_hold_no_tx", 64'(t0.size()), 64'd1);
            tx_busy = 1'b0;
        end
        foreach (data_q[k]) begin
            send_byte(data_q[k], $urandom_range(0, gap_max), c);
            data_c.push_back(c);
        end
        busy_rand = 1'b0;
        @(posedge clock);
        #2;
        tx_busy = 1'b0;
        step(8);
        check_model(size);
    endtask

    initial begin
        vec_t vt[8];
        int   c;
        int   np;
        logic [31:0] sz;

        // Test 1: single SYNC after reset, nothing else without input
        reset_and_sync(1'b0);
        step(20);
        chk("t1_single_tx_d0", 64'(t0.size()), 64'd1);
        chk("t1_single_tx_d1", 64'(t1.size()), 64'd1);

        // Test 6 then test 2: abort after 2 program bytes, then a clean 8-byte load
        reset_and_sync(1'b0);
        send_byte(8'h08, 0, c); send_byte(8'h00, 0, c); send_byte(8'h00, 0, c); send_byte(8'h00, 0, c);
        send_byte(8'h5A, 0, c); send_byte(8'hC3, 0, c);
        prog_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        data_q.delete();
        run_scenario(32'd8, 0, 2, 1'b1);
        chk("t2_word0", (i0.size() > 0) ? {16'(i0[0].addr), i0[0].data} : 64'hx, 64'h0_01020304);
        chk("t2_word1", (i0.size() > 1) ? {16'(i0[1].addr), i0[1].data} : 64'hx, 64'h1_05060708);

        // Test 3: size 0, DONE held back by tx_busy, then one data word
        prog_q.delete();
        data_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_scenario(32'd0, 2, 1, 1'b0);
        chk("t3_mem_word", (m0.size() > 0) ? 64'(m0[0].data) : 64'hx, 64'hDEADBEEF);

        // Test 4: size 6 rejected, later bytes ignored
        prog_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        data_q = '{8'h70, 8'h80, 8'h90, 8'hA0};
        run_scenario(32'd6, 0, 1, 1'b0);
        chk("t4_error", 64'(d0_error), 64'd1);

        // Test 5: LSB-first instance, back-to-back bytes
        prog_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        data_q.delete();
        run_scenario(32'd4, 0, 0, 1'b0);
        chk("t5_lsb_word", (i1.size() > 0) ? 64'(i1[0].data) : 64'hx, 64'h44332211);
        chk("t5_latency", (i1.size() > 0 && prog_c.size() > 3) ? 64'(i1[0].cyc - prog_c[3]) : 64'hx, 64'd0);

        // Size-field table including the address-range boundary
        vt[0] = '{size: 32'd8,          ndata: 4, exp_err: 1'b0, exp_tx: 8'hAA};
        vt[1] = '{size: 32'd6,          ndata: 4, exp_err: 1'b1, exp_tx: 8'hEE};
        vt[2] = '{size: 32'd0,          ndata: 8, exp_err: 1'b0, exp_tx: 8'hAA};
        vt[3] = '{size: 32'd64,         ndata: 4, exp_err: 1'b0, exp_tx: 8'hAA};
        vt[4] = '{size: 32'd68,         ndata: 4, exp_err: 1'b1, exp_tx: 8'hEE};
        vt[5] = '{size: 32'h4000_0000,  ndata: 2, exp_err: 1'b1, exp_tx: 8'hEE};
        vt[6] = '{size: 32'd4,          ndata: 7, exp_err: 1'b0, exp_tx: 8'hAA};
        vt[7] = '{size: 32'd1,          ndata: 0, exp_err: 1'b1, exp_tx: 8'hEE};
        for (int k = 0; k < 8; k++) begin
            prog_q.delete();
            data_q.delete();
            np = vt[k].exp_err ? 3 : int'(vt[k].size);
            for (int j = 0; j < np; j++) prog_q.push_back(8'($urandom));
            for (int j = 0; j < vt[k].ndata; j++) data_q.push_back(8'($urandom));
            run_scenario(vt[k].size, 0, 1, 1'b0);
            chk("tbl_error", 64'(d0_error), 64'(vt[k].exp_err));
            chk("tbl_last_tx", (t0.size() > 1) ? 64'(t0[t0.size()-1].data) : 64'hx, 64'(vt[k].exp_tx));
        end

        // Randomized scenarios
        for (int it = 0; it < 8; it++) begin
            case ($urandom_range(0, 4))
                0:       sz = 32'(4 * $urandom_range(1, 15) + $urandom_range(1, 3));
                1:       sz = 32'(MAXB + 4);
                default: sz = 32'(4 * $urandom_range(0, 16));
            endcase
            np = ((sz % 4) == 0 && sz <= MAXB) ? int'(sz) : $urandom_range(0, 5);
            prog_q.delete();
            data_q.delete();
            for (int j = 0; j < np; j++) prog_q.push_back(8'($urandom));
            for (int j = 0; j < int'($urandom_range(0, 10)); j++) data_q.push_back(8'($urandom));
            run_scenario(sz, $urandom_range(0, 1), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
